// File: rtl/cordic_pkg.sv
// Shared types and constants for the sequential linear-mode CORDIC multiplier.
package cordic_pkg;

  localparam int unsigned W  = 16;
  localparam int unsigned ZF = 13;
  localparam int unsigned XF = 14;
  localparam int unsigned IW = 4;

  localparam logic [W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [W-1:0] SAT_MIN = 16'h8000;
  localparam logic [W-1:0] Z_ONE   = W'(1) << ZF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic         ovf;
    logic [W-1:0] y;
  } sat_t;

  // Clamp a 17-bit signed sum into the 16-bit range and flag any clamping.
  function automatic sat_t saturate(input logic [W:0] s);
    sat_t r;
    r.ovf = 1'b0;
    r.y   = s[W-1:0];
    if (!s[W] && s[W-1]) begin
      r.y   = SAT_MAX;
      r.ovf = 1'b1;
    end else if (s[W] && !s[W-1]) begin
      r.y   = SAT_MIN;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_lin_mult_seq_if.sv
// Operand/product handshake bundle for the CORDIC multiplier.
interface cordic_lin_mult_seq_if;
  import cordic_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [W-1:0] z_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y_out;
  logic         ovf;

  modport master (
    output in_valid, x_in, z_in, out_ready,
    input  in_ready, out_valid, y_out, ovf
  );

  modport slave (
    input  in_valid, x_in, z_in, out_ready,
    output in_ready, out_valid, y_out, ovf
  );
endinterface

// File: rtl/cordic_acc_add.sv
// y-accumulation adder: approximate cell or exact 17-bit add, selected at build time.
module cordic_acc_add
  import cordic_pkg::*;
#(
  parameter bit APPROX = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);
  if (APPROX) begin : g_approx
    cordic_approx_add16 u_cell (
      .a   (a),
      .b   (b),
      .sum (sum)
    );
  end else begin : g_exact
    assign sum = {a[W-1], a} + {b[W-1], b};
  end
endmodule

// File: rtl/cordic_approx_add16.sv
// 16-bit sign-extended approximate adder: result bit 0 forced low, addend bit 0
// ignored, accumulator bit 0 used as carry into bit 1.
module cordic_approx_add16
  import cordic_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);
  logic [W:0] a_hi;
  logic [W:0] b_hi;
  logic [W:0] carry;

  assign a_hi  = {a[W-1], a} & {{W{1'b1}}, 1'b0};
  assign b_hi  = {b[W-1], b} & {{W{1'b1}}, 1'b0};
  assign carry = {(W-1)'(0), a[0], 1'b0};
  assign sum   = a_hi + b_hi + carry;
endmodule

// File: rtl/cordic_lin_mult_seq.sv
// Sequential linear-mode CORDIC multiplier: y = x * z, one micro-rotation per clock.
module cordic_lin_mult_seq
  import cordic_pkg::*;
#(
  parameter int unsigned ITER   = 14,
  parameter bit          APPROX = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  cordic_lin_mult_seq_if.slave bus
);

  state_t          state_r, state_nx;
  logic [W-1:0]    x_r, y_r, z_r, y_out_r;
  logic [W-1:0]    x_d, y_d, z_d, y_out_d;
  logic [IW-1:0]   i_r, i_d;
  logic            ovf_r, ovf_d;
  logic            out_valid_r, out_valid_d;
  logic            in_ready_r, in_ready_d;

  logic signed [W-1:0] xs;
  logic [W-1:0]        addend;
  logic [W-1:0]        step;
  logic [W:0]          sum;
  sat_t                sat;
  logic                last;

  assign xs     = $signed(x_r) >>> i_r;
  assign addend = z_r[W-1] ? W'(-xs) : W'(xs);
  assign step   = Z_ONE >> i_r;
  assign sat    = saturate(sum);
  assign last   = (i_r == IW'(ITER));

  cordic_acc_add #(.APPROX(APPROX)) u_acc_add (
    .a   (y_r),
    .b   (addend),
    .sum (sum)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      i_r         <= '0;
      ovf_r       <= 1'b0;
      y_out_r     <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx;
      x_r         <= x_d;
      y_r         <= y_d;
      z_r         <= z_d;
      i_r         <= i_d;
      ovf_r       <= ovf_d;
      y_out_r     <= y_out_d;
      out_valid_r <= out_valid_d;
      in_ready_r  <= in_ready_d;
    end
  end

  // Next-state logic; RUN spends one extra cycle after the last iteration to publish.
  always_comb begin
    state_nx = state_r;
    unique case (state_r)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    x_d         = x_r;
    y_d         = y_r;
    z_d         = z_r;
    i_d         = i_r;
    ovf_d       = ovf_r;
    y_out_d     = y_out_r;
    in_ready_d  = (state_nx == IDLE);
    out_valid_d = (state_nx == DONE);
    unique case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          x_d   = bus.x_in;
          z_d   = bus.z_in;
          y_d   = '0;
          i_d   = '0;
          ovf_d = 1'b0;
        end
      end
      RUN: begin
        if (last) begin
          y_out_d = y_r;
        end else begin
          i_d = i_r + IW'(1);
          // z == 0 means no further rotation: y and z hold.
          if (z_r != '0) begin
            y_d   = sat.y;
            ovf_d = ovf_r | sat.ovf;
            z_d   = z_r[W-1] ? z_r + step : z_r - step;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.y_out     = y_out_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_cordic_lin_mult_seq.sv
// Bench: exact and approximate builds side by side against an arithmetic reference model.
module tb_cordic_lin_mult_seq;

  localparam int ITER = 14;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] x_in;
  logic [15:0] z_in;

  int total = 0;
  int bad   = 0;

  cordic_lin_mult_seq_if bus0 ();
  cordic_lin_mult_seq_if bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.out_ready = out_ready;
  assign bus0.x_in      = x_in;
  assign bus0.z_in      = z_in;
  assign bus1.in_valid  = in_valid;
  assign bus1.out_ready = out_ready;
  assign bus1.x_in      = x_in;
  assign bus1.z_in      = z_in;

  cordic_lin_mult_seq #(.ITER(ITER), .APPROX(1'b0)) u_exact (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  cordic_lin_mult_seq #(.ITER(ITER), .APPROX(1'b1)) u_approx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: y accumulates +/- (x >> i) while z is driven to zero by 2^-i steps.
  function automatic void model(input logic [15:0] x, input logic [15:0] z, input bit approx,
                                output logic [15:0] y, output logic ovf);
    int xv, zv, yv, xs, ad, r;
    logic [15:0] zt;
    xv  = int'($signed(x));
    zv  = int'($signed(z));
    yv  = 0;
    ovf = 1'b0;
    for (int i = 0; i < ITER; i++) begin
      if (zv == 0) continue;
      xs = xv >>> i;
      ad = (zv > 0) ? xs : -xs;
      if (ad == 32768) ad = -32768;
      if (approx) r = 2 * ((yv >>> 1) + (ad >>> 1) + (yv & 1));
      else        r = yv + ad;
      if (r > 32767) begin
        r = 32767; ovf = 1'b1;
      end else if (r < -32768) begin
        r = -32768; ovf = 1'b1;
      end
      yv = r;
      zv = (zv > 0) ? zv - (8192 >> i) : zv + (8192 >> i);
      zt = 16'(zv);
      zv = int'($signed(zt));
    end
    y = 16'(yv);
  endfunction

  // One full operation: accept, optional in_valid pulse during RUN, wait, check, hold, release.
  task automatic run_op(input logic [15:0] x, input logic [15:0] z, input int hold,
                        input bit pulse, output logic [15:0] y0, output logic [15:0] y1,
                        output logic o0, output logic o1);
    int lat;
    logic [15:0] ey0, ey1;
    logic eo0, eo1;
    model(x, z, 1'b0, ey0, eo0);
    model(x, z, 1'b1, ey1, eo1);
    @(negedge clk);
    chk("in_ready_idle", {bus0.in_ready, bus1.in_ready}, 32'h3);
    in_valid  = 1'b1;
    x_in      = x;
    z_in      = z;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in     = 16'h0;
    z_in     = 16'h0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (pulse && lat == 3) begin
        in_valid = 1'b1; x_in = 16'h7FFF; z_in = 16'h3FFF;
      end
      if (pulse && lat == 5) in_valid = 1'b0;
      if (bus0.out_valid || bus1.out_valid) break;
    end
    chk("latency", 32'(lat), 32'(ITER + 1));
    chk("out_valid_both", {bus0.out_valid, bus1.out_valid}, 32'h3);
    chk("y_exact", bus0.y_out, ey0);
    chk("y_approx", bus1.y_out, ey1);
    chk("ovf_exact", bus0.ovf, eo0);
    chk("ovf_approx", bus1.ovf, eo1);
    y0 = bus0.y_out; y1 = bus1.y_out; o0 = bus0.ovf; o1 = bus1.ovf;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {bus0.out_valid, bus1.out_valid, bus0.in_ready}, 32'h6);
      chk("hold_y", {bus0.y_out, bus1.y_out}, {ey0, ey1});
      chk("hold_ovf", {bus0.ovf, bus1.ovf}, {eo0, eo1});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("released", {bus0.out_valid, bus1.out_valid, bus0.in_ready, bus1.in_ready}, 32'h3);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] y0, y1, x, z;
    logic o0, o1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; z_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {bus0.in_ready, bus0.out_valid, bus1.in_ready, bus1.out_valid}, 32'hA);
    chk("reset_y", {bus0.y_out, bus1.y_out}, 32'h0);
    chk("reset_ovf", {bus0.ovf, bus1.ovf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h2000, 16'h2000, 0, 1'b0, y0, y1, o0, o1);
    chk("one_times_half", {y0, y1, 14'h0, o0, o1}, {16'h2000, 16'h2000, 16'h0});
    run_op(16'h2000, 16'h1000, 0, 1'b0, y0, y1, o0, o1);
    chk("half_times_half", {y0, y1}, {16'h1000, 16'h1000});
    run_op(16'h2000, 16'hE000, 0, 1'b0, y0, y1, o0, o1);
    chk("neg_one", {y0, y1}, {16'hE000, 16'hE000});
    run_op(16'h0003, 16'h2000, 0, 1'b0, y0, y1, o0, o1);
    chk("lsb_approx", {y0, y1}, {16'h0003, 16'h0002});
    run_op(16'h7FFF, 16'h3FFF, 0, 1'b0, y0, y1, o0, o1);
    chk("saturate", {y0, y1, 14'h0, o0, o1}, {16'h7FFF, 16'h7FFF, 16'h3});
    run_op(16'h1234, 16'h0C00, 5, 1'b0, y0, y1, o0, o1);
    run_op(16'h2000, 16'h1000, 0, 1'b1, y0, y1, o0, o1);
    chk("ignore_in_valid", {y0, y1, 14'h0, o0, o1}, {16'h1000, 16'h1000, 16'h0});

    // Reset during RUN: everything returns to reset values without a clock edge.
    @(negedge clk);
    in_valid = 1'b1; x_in = 16'h4000; z_in = 16'h1800;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", {bus0.in_ready, bus0.out_valid, bus1.in_ready, bus1.out_valid}, 32'hA);
    chk("async_reset_y", {bus0.y_out, bus1.y_out, 14'h0, bus0.ovf, bus1.ovf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h2000, 16'h2000, 0, 1'b0, y0, y1, o0, o1);

    for (int n = 0; n < 12; n++) begin
      x = 16'($urandom);
      z = 16'($urandom_range(0, 32766) - 16383);
      run_op(x, z, int'($urandom_range(0, 2)), 1'b0, y0, y1, o0, o1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
